enigma_rotor_ctrl: RTL
======================

Name: enigma_rotor_ctrl

Overview:
Sequencer for the 64-symbol rotor cipher datapath. It accepts one 6-bit plaintext symbol per transaction and steps the three rotor positions (A fast, B middle, C slow) with notch and double-step rules. It then time-multiplexes a single shared table-lookup port through seven passes: A, B, C forward, reflector, then C, B, A inverse. The block sits between the character stream interface and the combinational rotor/reflector lookup muxes.

Parameters:
NOTCH_A, 63, rotor A position at which the next step also advances rotor B
NOTCH_B, 63, rotor B position at which the next step advances rotor C and double-steps B

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  plaintext symbol valid
in_ready  out  1  block can accept a symbol
in_sym  in  6  plaintext symbol
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts ciphertext
out_sym  out  6  ciphertext symbol
cfg_we  in  1  load rotor start positions
cfg_pos_a/cfg_pos_b/cfg_pos_c  in  6 each  start positions
pos_a/pos_b/pos_c  out  6 each  current rotor positions
tbl_sel  out  3  0=A fwd, 1=B fwd, 2=C fwd, 3=reflector, 4=C inv, 5=B inv, 6=A inv, 7=idle
tbl_addr  out  6  lookup address to selected table
tbl_data  in  6  combinational lookup result, same cycle

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state IDLE, pos_a/b/c=0, out_valid=0, out_sym=0, tbl_sel=7, tbl_addr=0, in_ready=1.
- FSM states: IDLE, STEP, L0..L6, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready latches in_sym into the working register and moves to STEP.
  - cfg_we loads pos_a/b/c the following cycle.
  - If cfg_we and in_valid are both high, cfg wins, in_ready=0 that cycle, and the symbol is not accepted.
- STEP (1 cycle). All decisions use pre-step values:
  - A always increments.
  - B increments if pos_a==NOTCH_A or pos_b==NOTCH_B.
  - C increments if pos_b==NOTCH_B.
  - All arithmetic is mod 64 (63 wraps to 0).
- L0..L6 (1 cycle each):
  - tbl_sel = 0..6 in order.
  - For rotor passes: tbl_addr = (w + pos_r) mod 64 and w <= (tbl_data - pos_r) mod 64, using the post-step position of that rotor.
  - Reflector pass (L3): tbl_addr = w, w <= tbl_data, no offset.
  - tbl_sel=7 outside L states.
- DONE:
  - out_valid=1, out_sym=w; both held stable until out_ready.
  - out_valid&out_ready returns to IDLE next cycle.
  - in_ready=0 in all states except IDLE.
- Latency: acceptance at cycle N gives out_valid at cycle N+9. Minimum throughput is one symbol per 10 cycles.
- cfg_we outside IDLE is ignored; positions are unaffected.
- reset in any state aborts the transaction, discards the symbol, and restores reset values next cycle.
- out_ready is ignored when out_valid=0.

Optional Feature:
CHAR_COUNT_EN:
- When defined: adds output char_count [15:0]. Reset 0; increments on each out_valid&out_ready; wraps 65535 to 0; cleared by cfg_we accepted in IDLE.
- When undefined: the port and counter are absent.

Test Plan:
- Identity rotor tables, reflector r(x)=63-x; reset, send in_sym=5 -> out_sym=58 at acceptance+9 cycles; pos_a=1, pos_b=0, pos_c=0.
- cfg pos=(3,0,0), send in_sym=10 -> in STEP pos_a becomes 4; L0 shows tbl_sel=0, tbl_addr=14; sequence of tbl_sel observed 0,1,2,3,4,5,6.
- Notch and double step:
  - cfg (63,0,0), one symbol -> (0,1,0).
  - cfg (10,63,5), one symbol -> (11,0,6).
  - cfg (63,63,63) -> (0,0,0).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sym stable, in_ready=0, second in_valid not accepted; out_ready=1 -> IDLE next cycle.
- Simultaneous cfg_we=1 and in_valid=1 in IDLE -> positions loaded, symbol not accepted (in_ready=0), accepted next cycle; cfg_we during L2 -> ignored.
- Assert reset during L4 -> next cycle state IDLE, out_valid=0, positions 0, tbl_sel=7; no output produced. With CHAR_COUNT_EN, 3 completed symbols -> char_count=3.

Source files
------------

// File: rtl/enigma_rotor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enigma_rotor_ctrl
// Purpose  : Steps three rotor positions per 6-bit symbol and walks one shared
//            lookup port through A/B/C forward, reflector, C/B/A inverse.
//            Optional CHAR_COUNT_EN adds a completed-symbol counter output.
// Revision : 1.0  initial release
// ============================================================================
module enigma_rotor_ctrl #(
    parameter logic [5:0] NOTCH_A = 6'd63,
    parameter logic [5:0] NOTCH_B = 6'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_sym,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_sym,
    input  logic        cfg_we,
    input  logic [5:0]  cfg_pos_a,
    input  logic [5:0]  cfg_pos_b,
    input  logic [5:0]  cfg_pos_c,
    output logic [5:0]  pos_a,
    output logic [5:0]  pos_b,
    output logic [5:0]  pos_c,
    output logic [2:0]  tbl_sel,
    output logic [5:0]  tbl_addr,
`ifdef CHAR_COUNT_EN
    output logic [15:0] char_count,
`endif
    input  logic [5:0]  tbl_data
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_STEP = 4'd1,
        S_L0   = 4'd2,
        S_L1   = 4'd3,
        S_L2   = 4'd4,
        S_L3   = 4'd5,
        S_L4   = 4'd6,
        S_L5   = 4'd7,
        S_L6   = 4'd8,
        S_DONE = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_work;
    logic [5:0] w_work_next;
    logic [5:0] r_pos_a;
    logic [5:0] r_pos_b;
    logic [5:0] r_pos_c;
    logic [5:0] w_pos_a_next;
    logic [5:0] w_pos_b_next;
    logic [5:0] w_pos_c_next;
    logic [5:0] w_rot_pos;
    logic       w_lookup;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_pos_a <= '0;
            r_pos_b <= '0;
            r_pos_c <= '0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_pos_a <= w_pos_a_next;
            r_pos_b <= w_pos_b_next;
            r_pos_c <= w_pos_c_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_pos_a_next = r_pos_a;
        w_pos_b_next = r_pos_b;
        w_pos_c_next = r_pos_c;
        w_rot_pos    = '0;
        w_lookup     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_sym      = '0;
        tbl_sel      = 3'd7;
        tbl_addr     = '0;

        case (r_state)
            S_IDLE: begin
                // A configuration write pre-empts a symbol offered in the same cycle.
                in_ready = ~cfg_we;
                if (cfg_we) begin
                    w_pos_a_next = cfg_pos_a;
                    w_pos_b_next = cfg_pos_b;
                    w_pos_c_next = cfg_pos_c;
                end else if (in_valid) begin
                    w_work_next  = in_sym;
                    w_state_next = S_STEP;
                end
            end
            S_STEP: begin
                w_pos_a_next = r_pos_a + 6'd1;
                if ((r_pos_a == NOTCH_A) || (r_pos_b == NOTCH_B)) begin
                    w_pos_b_next = r_pos_b + 6'd1;
                end
                if (r_pos_b == NOTCH_B) begin
                    w_pos_c_next = r_pos_c + 6'd1;
                end
                w_state_next = S_L0;
            end
            S_L0: begin tbl_sel = 3'd0; w_rot_pos = r_pos_a; w_lookup = 1'b1; w_state_next = S_L1; end
            S_L1: begin tbl_sel = 3'd1; w_rot_pos = r_pos_b; w_lookup = 1'b1; w_state_next = S_L2; end
            S_L2: begin tbl_sel = 3'd2; w_rot_pos = r_pos_c; w_lookup = 1'b1; w_state_next = S_L3; end
            // The reflector is a lookup with a zero rotor offset.
            S_L3: begin tbl_sel = 3'd3; w_rot_pos = 6'd0;    w_lookup = 1'b1; w_state_next = S_L4; end
            S_L4: begin tbl_sel = 3'd4; w_rot_pos = r_pos_c; w_lookup = 1'b1; w_state_next = S_L5; end
            S_L5: begin tbl_sel = 3'd5; w_rot_pos = r_pos_b; w_lookup = 1'b1; w_state_next = S_L6; end
            S_L6: begin tbl_sel = 3'd6; w_rot_pos = r_pos_a; w_lookup = 1'b1; w_state_next = S_DONE; end
            S_DONE: begin
                out_valid = 1'b1;
                out_sym   = r_work;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_lookup) begin
            tbl_addr    = r_work + w_rot_pos;
            w_work_next = tbl_data - w_rot_pos;
        end
    end

    assign pos_a = r_pos_a;
    assign pos_b = r_pos_b;
    assign pos_c = r_pos_c;

`ifdef CHAR_COUNT_EN
    logic [15:0] r_char_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_char_count <= '0;
        end else if ((r_state == S_IDLE) && cfg_we) begin
            r_char_count <= '0;
        end else if ((r_state == S_DONE) && out_ready) begin
            r_char_count <= r_char_count + 16'd1;
        end
    end

    assign char_count = r_char_count;
`endif

endmodule
`default_nettype wire
